// File: rtl/dir_column_sum_pkg.sv
// Shared edge-path constants: direction codes and adder-tree sizing helper.
package edge_pkg;

   typedef enum logic [3:0] {
      DIR_135_180 = 4'b0001,
      DIR_0_45    = 4'b0010,
      DIR_90_135  = 4'b0100,
      DIR_45_90   = 4'b1000
   } dir_e;

   localparam dir_e DIR_DEFAULT = DIR_0_45;

   // Operand count feeding adder-tree level lvl, starting from n leaves.
   function automatic int unsigned level_count(input int unsigned n, input int unsigned lvl);
      int unsigned c;
      c = n;
      for (int unsigned i = 0; i < lvl; i++) c = (c + 1) / 2;
      return c;
   endfunction

endpackage

// File: rtl/dir_column_sum_if.sv
// Window/direction input and line-sum output bundle of the column-sum stage.
interface dir_column_sum_if #(
   parameter int unsigned PIX_W   = 8,
   parameter int unsigned WIN     = 7,
   parameter int unsigned SUM_LEN = 5
);
   localparam int unsigned SUM_W = PIX_W + $clog2(SUM_LEN);

   logic                     i_valid;
   logic [3:0]               i_state;
   logic [WIN*WIN*PIX_W-1:0] i_win;
   logic                     o_valid;
   logic [3:0]               o_state;
   logic                     o_state_err;
   logic [SUM_W-1:0]         o_sl;
   logic [SUM_W-1:0]         o_sm;
   logic [SUM_W-1:0]         o_sr;

   modport master (
      output i_valid, i_state, i_win,
      input  o_valid, o_state, o_state_err, o_sl, o_sm, o_sr
   );

   modport slave (
      input  i_valid, i_state, i_win,
      output o_valid, o_state, o_state_err, o_sl, o_sm, o_sr
   );
endinterface

// File: rtl/dir_column_sum_sum_tree.sv
// Registered pairwise adder tree: $clog2(N) levels, odd leftovers passed through.
module sum_tree
   import edge_pkg::*;
#(
   parameter int unsigned N    = 5,
   parameter int unsigned IN_W = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ce,
   input  logic [N*IN_W-1:0]           ops,
   output logic [IN_W+$clog2(N)-1:0]   sum
);
   localparam int unsigned T     = $clog2(N);
   localparam int unsigned OUT_W = IN_W + T;

   for (genvar l = 0; l < T; l++) begin : g_lvl
      localparam int unsigned CNT = level_count(N, l);

      // src is padded to 2N so the pair index 2j+1 never leaves the array
      logic [OUT_W-1:0] src [2*N];
      logic [OUT_W-1:0] q   [N];

      if (l == 0) begin : g_first
         always_comb begin
            for (int unsigned j = 0; j < 2*N; j++) src[j] = '0;
            for (int unsigned j = 0; j < N; j++) src[j] = OUT_W'(ops[j*IN_W +: IN_W]);
         end
      end else begin : g_next
         always_comb begin
            for (int unsigned j = 0; j < 2*N; j++) src[j] = '0;
            for (int unsigned j = 0; j < N; j++) src[j] = g_lvl[l-1].q[j];
         end
      end

      always_ff @(posedge clk) begin
         if (!rst) begin
            for (int unsigned j = 0; j < N; j++) q[j] <= '0;
         end else if (ce) begin
            for (int unsigned j = 0; j < N; j++) begin
               if (2*j + 1 < CNT)  q[j] <= src[2*j] + src[2*j+1];
               else if (2*j < CNT) q[j] <= src[2*j];
               else                q[j] <= '0;
            end
         end
      end
   end

   assign sum = g_lvl[T-1].q[0];

endmodule

// File: rtl/dir_column_sum.sv
// Directional column-sum stage: picks three SUM_LEN-pixel lines per window by
// gradient direction and sums each through a registered adder tree.
module dir_column_sum
   import edge_pkg::*;
#(
   parameter int unsigned PIX_W   = 8,
   parameter int unsigned WIN     = 7,
   parameter int unsigned SUM_LEN = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce,
   dir_column_sum_if.slave        dcs
);
   localparam int unsigned SUM_W = PIX_W + $clog2(SUM_LEN);
   localparam int unsigned T     = $clog2(SUM_LEN);
   localparam int          C     = int'((WIN + 1) / 2);
   localparam int          H     = int'((SUM_LEN - 1) / 2);

   if (WIN % 2 == 0) begin : g_chk_win
      $error("dir_column_sum: WIN must be odd");
   end
   if (SUM_LEN % 2 == 0) begin : g_chk_len
      $error("dir_column_sum: SUM_LEN must be odd");
   end
   if (SUM_LEN + 2 > WIN) begin : g_chk_fit
      $error("dir_column_sum: SUM_LEN+2 must not exceed WIN");
   end

   logic [3:0]       dir_d;
   logic             err_d;
   logic [PIX_W-1:0] taps_d [3][SUM_LEN];
   logic [PIX_W-1:0] taps_q [3][SUM_LEN];
   logic [3:0]       state_q [T+1];
   logic             err_q   [T+1];
   logic             valid_q [T+1];
   logic [SUM_LEN*PIX_W-1:0] ops [3];

   always_comb begin
      dir_d = DIR_DEFAULT;
      err_d = 1'b1;
      case (dcs.i_state)
         DIR_135_180, DIR_0_45, DIR_90_135, DIR_45_90: begin
            dir_d = dcs.i_state;
            err_d = 1'b0;
         end
         default: ;
      endcase
   end

   // Line k in {-1,0,1}; the along-line centre is shifted by +k or -k by direction
   always_comb begin
      int k, t, row, col;
      k = 0; t = 0; row = 0; col = 0;
      for (int unsigned li = 0; li < 3; li++) begin
         for (int unsigned ti = 0; ti < SUM_LEN; ti++) begin
            k = int'(li) - 1;
            t = int'(ti) - H;
            case (dir_d)
               DIR_135_180: begin row = C + k + t; col = C + k;     end
               DIR_0_45:    begin row = C - k + t; col = C + k;     end
               DIR_90_135:  begin row = C + k;     col = C + k + t; end
               default:     begin row = C + k;     col = C - k + t; end
            endcase
            taps_d[li][ti] = dcs.i_win[((row - 1) * int'(WIN) + (col - 1)) * int'(PIX_W) +: PIX_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned li = 0; li < 3; li++)
            for (int unsigned ti = 0; ti < SUM_LEN; ti++) taps_q[li][ti] <= '0;
         for (int unsigned s = 0; s <= T; s++) begin
            state_q[s] <= '0;
            err_q[s]   <= 1'b0;
            valid_q[s] <= 1'b0;
         end
      end else if (ce) begin
         taps_q     <= taps_d;
         state_q[0] <= dir_d;
         err_q[0]   <= err_d;
         valid_q[0] <= dcs.i_valid;
         for (int unsigned s = 1; s <= T; s++) begin
            state_q[s] <= state_q[s-1];
            err_q[s]   <= err_q[s-1];
            valid_q[s] <= valid_q[s-1];
         end
      end
   end

   always_comb begin
      for (int unsigned li = 0; li < 3; li++) begin
         ops[li] = '0;
         for (int unsigned ti = 0; ti < SUM_LEN; ti++)
            ops[li][ti*PIX_W +: PIX_W] = taps_q[li][ti];
      end
   end

   sum_tree #(.N(SUM_LEN), .IN_W(PIX_W)) u_sum_l (
      .clk(clk), .rst(rst), .ce(ce), .ops(ops[0]), .sum(dcs.o_sl)
   );
   sum_tree #(.N(SUM_LEN), .IN_W(PIX_W)) u_sum_m (
      .clk(clk), .rst(rst), .ce(ce), .ops(ops[1]), .sum(dcs.o_sm)
   );
   sum_tree #(.N(SUM_LEN), .IN_W(PIX_W)) u_sum_r (
      .clk(clk), .rst(rst), .ce(ce), .ops(ops[2]), .sum(dcs.o_sr)
   );

   assign dcs.o_valid     = valid_q[T];
   assign dcs.o_state     = state_q[T];
   assign dcs.o_state_err = err_q[T];

endmodule

// File: tb/tb_dir_column_sum.sv
// Directed self-checking bench for dir_column_sum at default parameters.
module tb_dir_column_sum;
   localparam int unsigned PIX_W   = 8;
   localparam int unsigned WIN     = 7;
   localparam int unsigned SUM_LEN = 5;
   localparam int unsigned SUM_W   = 11;
   localparam int unsigned WB      = WIN * WIN * PIX_W;

   logic clk = 1'b0;
   logic rst;
   logic ce;
   always #5 clk = ~clk;

   dir_column_sum_if #(.PIX_W(PIX_W), .WIN(WIN), .SUM_LEN(SUM_LEN)) dcs ();

   dir_column_sum #(.PIX_W(PIX_W), .WIN(WIN), .SUM_LEN(SUM_LEN)) dut (
      .clk(clk), .rst(rst), .ce(ce), .dcs(dcs)
   );

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   logic [3:0] codes [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

   function automatic logic [WB-1:0] ramp_win();
      logic [WB-1:0] w;
      w = '0;
      for (int unsigned r = 1; r <= WIN; r++)
         for (int unsigned c = 1; c <= WIN; c++)
            w[((r-1)*WIN + (c-1))*PIX_W +: PIX_W] = PIX_W'(10*r + c);
      return w;
   endfunction

   function automatic logic [WB-1:0] flat_win(input int unsigned v);
      logic [WB-1:0] w;
      for (int unsigned p = 0; p < WIN*WIN; p++) w[p*PIX_W +: PIX_W] = PIX_W'(v);
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; ce = 1'b1;
      dcs.i_valid = 1'b0; dcs.i_state = 4'b0000; dcs.i_win = '0;
      tick(); tick();
      n_chk++; if (dcs.o_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", dcs.o_valid); else n_pass++;
      n_chk++; if (dcs.o_state !== 4'b0000) $display("FAIL reset_state got %b want 0000", dcs.o_state); else n_pass++;
      n_chk++; if (dcs.o_state_err !== 1'b0) $display("FAIL reset_err got %b want 0", dcs.o_state_err); else n_pass++;
      n_chk++; if (dcs.o_sl !== 11'd0 || dcs.o_sm !== 11'd0 || dcs.o_sr !== 11'd0)
         $display("FAIL reset_sums got %0d/%0d/%0d want 0/0/0", dcs.o_sl, dcs.o_sm, dcs.o_sr); else n_pass++;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_directions();
      int unsigned exp_l [4] = '{165, 265, 165, 175};
      int unsigned exp_r [4] = '{275, 175, 275, 265};
      for (int unsigned i = 0; i < 4; i++) begin
         dcs.i_valid = 1'b1; dcs.i_state = codes[i]; dcs.i_win = ramp_win();
         tick();
         dcs.i_valid = 1'b0; dcs.i_win = '0;
         tick(); tick();
         n_chk++; if (dcs.o_valid !== 1'b0) $display("FAIL dir%0d_early_valid got %b want 0", i, dcs.o_valid); else n_pass++;
         tick();
         n_chk++; if (dcs.o_valid !== 1'b1) $display("FAIL dir%0d_valid got %b want 1", i, dcs.o_valid); else n_pass++;
         n_chk++; if (dcs.o_sl !== SUM_W'(exp_l[i])) $display("FAIL dir%0d_sl got %0d want %0d", i, dcs.o_sl, exp_l[i]); else n_pass++;
         n_chk++; if (dcs.o_sm !== 11'd220) $display("FAIL dir%0d_sm got %0d want 220", i, dcs.o_sm); else n_pass++;
         n_chk++; if (dcs.o_sr !== SUM_W'(exp_r[i])) $display("FAIL dir%0d_sr got %0d want %0d", i, dcs.o_sr, exp_r[i]); else n_pass++;
         n_chk++; if (dcs.o_state !== codes[i]) $display("FAIL dir%0d_state got %b want %b", i, dcs.o_state, codes[i]); else n_pass++;
         n_chk++; if (dcs.o_state_err !== 1'b0) $display("FAIL dir%0d_err got %b want 0", i, dcs.o_state_err); else n_pass++;
      end
   endtask

   task automatic test_state_err();
      logic [3:0]  in_st  [3] = '{4'b0011, 4'b0001, 4'b0000};
      logic [3:0]  exp_st [3] = '{4'b0010, 4'b0001, 4'b0010};
      logic        exp_er [3] = '{1'b1, 1'b0, 1'b1};
      int unsigned exp_l  [3] = '{265, 165, 265};
      int unsigned exp_r  [3] = '{175, 275, 175};
      for (int unsigned i = 0; i < 6; i++) begin
         if (i < 3) begin
            dcs.i_valid = 1'b1; dcs.i_state = in_st[i]; dcs.i_win = ramp_win();
         end else begin
            dcs.i_valid = 1'b0; dcs.i_state = 4'b0000; dcs.i_win = '0;
         end
         tick();
         if (i >= 3) begin
            n_chk++; if (dcs.o_valid !== 1'b1) $display("FAIL err%0d_valid got %b want 1", i-3, dcs.o_valid); else n_pass++;
            n_chk++; if (dcs.o_state !== exp_st[i-3]) $display("FAIL err%0d_state got %b want %b", i-3, dcs.o_state, exp_st[i-3]); else n_pass++;
            n_chk++; if (dcs.o_state_err !== exp_er[i-3]) $display("FAIL err%0d_flag got %b want %b", i-3, dcs.o_state_err, exp_er[i-3]); else n_pass++;
            n_chk++; if (dcs.o_sl !== SUM_W'(exp_l[i-3]) || dcs.o_sm !== 11'd220 || dcs.o_sr !== SUM_W'(exp_r[i-3]))
               $display("FAIL err%0d_sums got %0d/%0d/%0d want %0d/220/%0d", i-3, dcs.o_sl, dcs.o_sm, dcs.o_sr, exp_l[i-3], exp_r[i-3]);
            else n_pass++;
         end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      for (int unsigned i = 0; i < 24; i++) begin
         if (i < 20) begin
            dcs.i_valid = 1'b1; dcs.i_state = codes[i % 4]; dcs.i_win = flat_win(255);
         end else begin
            dcs.i_valid = 1'b0; dcs.i_win = '0;
         end
         tick();
         if (i >= 3 && i < 23) begin
            n_chk++; if (dcs.o_valid !== 1'b1) $display("FAIL b2b%0d_valid got %b want 1", i-3, dcs.o_valid); else n_pass++;
            n_chk++; if (dcs.o_sl !== 11'd1275 || dcs.o_sm !== 11'd1275 || dcs.o_sr !== 11'd1275)
               $display("FAIL b2b%0d_sums got %0d/%0d/%0d want 1275", i-3, dcs.o_sl, dcs.o_sm, dcs.o_sr); else n_pass++;
            n_chk++; if (dcs.o_state !== codes[(i-3) % 4])
               $display("FAIL b2b%0d_state got %b want %b", i-3, dcs.o_state, codes[(i-3) % 4]); else n_pass++;
         end else if (i == 23) begin
            n_chk++; if (dcs.o_valid !== 1'b0) $display("FAIL b2b_tail_valid got %b want 0", dcs.o_valid); else n_pass++;
         end
      end
   endtask

   task automatic test_stall();
      logic        ev  [4];
      int unsigned val [4];
      logic [3:0]  est [4];
      int unsigned j;
      logic        stall;
      j = 0;
      for (int unsigned s = 0; s < 4; s++) begin ev[s] = 1'b0; val[s] = 0; est[s] = '0; end
      for (int unsigned c = 0; c < 15; c++) begin
         stall = (c >= 5 && c <= 7);
         ce = !stall;
         if (stall) begin
            dcs.i_valid = 1'b1; dcs.i_state = 4'b0001; dcs.i_win = flat_win(200);
         end else if (j < 8) begin
            dcs.i_valid = 1'b1; dcs.i_state = codes[j % 4]; dcs.i_win = flat_win(10 + j);
         end else begin
            dcs.i_valid = 1'b0; dcs.i_win = '0;
         end
         if (!stall) begin
            for (int s = 3; s > 0; s--) begin ev[s] = ev[s-1]; val[s] = val[s-1]; est[s] = est[s-1]; end
            ev[0] = dcs.i_valid; val[0] = 10 + j; est[0] = dcs.i_state;
            if (j < 8) j++;
         end
         tick();
         n_chk++; if (dcs.o_valid !== ev[3]) $display("FAIL stall_c%0d_valid got %b want %b", c, dcs.o_valid, ev[3]); else n_pass++;
         if (ev[3]) begin
            n_chk++; if (dcs.o_sl !== SUM_W'(5*val[3]) || dcs.o_sm !== SUM_W'(5*val[3]) || dcs.o_sr !== SUM_W'(5*val[3]))
               $display("FAIL stall_c%0d_sums got %0d/%0d/%0d want %0d", c, dcs.o_sl, dcs.o_sm, dcs.o_sr, 5*val[3]); else n_pass++;
            n_chk++; if (dcs.o_state !== est[3]) $display("FAIL stall_c%0d_state got %b want %b", c, dcs.o_state, est[3]); else n_pass++;
         end
      end
      ce = 1'b1;
   endtask

   task automatic test_reset_midstream();
      for (int unsigned i = 0; i < 3; i++) begin
         dcs.i_valid = 1'b1; dcs.i_state = codes[i]; dcs.i_win = flat_win(50 + 10*i);
         tick();
      end
      rst = 1'b0; ce = 1'b0;
      tick();
      n_chk++; if (dcs.o_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", dcs.o_valid); else n_pass++;
      n_chk++; if (dcs.o_state !== 4'b0000 || dcs.o_state_err !== 1'b0)
         $display("FAIL midrst_state got %b/%b want 0000/0", dcs.o_state, dcs.o_state_err); else n_pass++;
      n_chk++; if (dcs.o_sl !== 11'd0 || dcs.o_sm !== 11'd0 || dcs.o_sr !== 11'd0)
         $display("FAIL midrst_sums got %0d/%0d/%0d want 0/0/0", dcs.o_sl, dcs.o_sm, dcs.o_sr); else n_pass++;
      rst = 1'b1; ce = 1'b1; dcs.i_valid = 1'b0; dcs.i_win = '0;
      for (int unsigned i = 0; i < 6; i++) begin
         tick();
         n_chk++; if (dcs.o_valid !== 1'b0) $display("FAIL midrst_stale%0d got %b want 0", i, dcs.o_valid); else n_pass++;
      end
      dcs.i_valid = 1'b1; dcs.i_state = 4'b0001; dcs.i_win = ramp_win();
      tick();
      dcs.i_valid = 1'b0; dcs.i_win = '0;
      tick(); tick();
      n_chk++; if (dcs.o_valid !== 1'b0) $display("FAIL postrst_early got %b want 0", dcs.o_valid); else n_pass++;
      tick();
      n_chk++; if (dcs.o_valid !== 1'b1) $display("FAIL postrst_valid got %b want 1", dcs.o_valid); else n_pass++;
      n_chk++; if (dcs.o_sl !== 11'd165 || dcs.o_sm !== 11'd220 || dcs.o_sr !== 11'd275)
         $display("FAIL postrst_sums got %0d/%0d/%0d want 165/220/275", dcs.o_sl, dcs.o_sm, dcs.o_sr); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_directions();
      test_state_err();
      test_back_to_back();
      test_stall();
      test_reset_midstream();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
